// File: rtl/inst_decode_queue_pkg.sv
// rtl/inst_decode_queue_pkg.sv - RV64 opcodes, immediate-type selector encoding and NOP constant.
package rv_decode_pkg;

   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;

   typedef enum logic [2:0] {
      IMM_U    = 3'b000,
      IMM_J    = 3'b001,
      IMM_I    = 3'b010,
      IMM_B    = 3'b011,
      IMM_S    = 3'b100,
      IMM_NONE = 3'b111
   } imm_type_e;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/inst_decode_queue_if.sv
// rtl/inst_decode_queue_if.sv - Fetch-side and decode-side handshake bundle of the instruction queue.
interface inst_decode_queue_if #(
   parameter int DEPTH = 2,
   parameter int PC_W  = 64
);
   logic                     flush;
   logic                     in_valid;
   logic                     in_ready;
   logic [31:0]              in_inst;
   logic [PC_W-1:0]          in_pc;
   logic                     out_valid;
   logic                     out_ready;
   logic [31:0]              out_inst;
   logic [PC_W-1:0]          out_pc;
   logic [2:0]               out_imm_type;
   logic                     out_illegal;
   logic [$clog2(DEPTH):0]   count;

   modport master (
      output flush, in_valid, in_inst, in_pc, out_ready,
      input  in_ready, out_valid, out_inst, out_pc, out_imm_type, out_illegal, count
   );

   modport slave (
      input  flush, in_valid, in_inst, in_pc, out_ready,
      output in_ready, out_valid, out_inst, out_pc, out_imm_type, out_illegal, count
   );
endinterface

// File: rtl/imm_type_decoder.sv
// rtl/imm_type_decoder.sv - Combinational opcode to immediate-type selector and illegal flag.
module imm_type_decoder
   import rv_decode_pkg::*;
(
   input  logic [6:0] opcode_i,
   output imm_type_e  imm_type_o,
   output logic       illegal_o
);
   always_comb begin
      imm_type_o = IMM_NONE;
      illegal_o  = 1'b0;
      // Opcodes with inst[1:0] != 2'b11 never match an entry and land in default.
      unique case (opcode_i)
         OPC_LUI, OPC_AUIPC:                 imm_type_o = IMM_U;
         OPC_JAL:                            imm_type_o = IMM_J;
         OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32,
         OPC_SYSTEM, OPC_MISC_MEM:           imm_type_o = IMM_I;
         OPC_BRANCH:                         imm_type_o = IMM_B;
         OPC_STORE:                          imm_type_o = IMM_S;
         OPC_OP, OPC_OP_32:                  imm_type_o = IMM_NONE;
         default:                            illegal_o  = 1'b1;
      endcase
   end
endmodule

// File: rtl/inst_decode_queue.sv
// rtl/inst_decode_queue.sv - Circular instruction queue between fetch and decode with pre-decoded immediate type.
module inst_decode_queue
   import rv_decode_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int PC_W  = 64
) (
   input  logic                clk,
   input  logic                rst_n,
   inst_decode_queue_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [31:0]      inst_mem [DEPTH];
   logic [PC_W-1:0]  pc_mem   [DEPTH];
   imm_type_e        imm_mem  [DEPTH];
   logic             ill_mem  [DEPTH];

   logic      full, empty, push, pop;
   imm_type_e dec_imm_type;
   logic      dec_illegal;

   imm_type_decoder u_dec (
      .opcode_i   (bus.in_inst[6:0]),
      .imm_type_o (dec_imm_type),
      .illegal_o  (dec_illegal)
   );

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   // Push acceptance depends only on current occupancy, so a pop cannot make room in the same cycle.
   assign push  = bus.in_valid & ~full;
   assign pop   = bus.out_ready & ~empty;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (push && !pop)      count_d = count_q + CNT_W'(1);
         else if (pop && !push) count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !bus.flush) begin
         inst_mem[wr_ptr_q] <= bus.in_inst;
         pc_mem[wr_ptr_q]   <= bus.in_pc;
         imm_mem[wr_ptr_q]  <= dec_imm_type;
         ill_mem[wr_ptr_q]  <= dec_illegal;
      end
   end

   assign bus.in_ready     = ~full;
   assign bus.out_valid    = ~empty;
   assign bus.count        = count_q;
   assign bus.out_inst     = empty ? NOP_INST : inst_mem[rd_ptr_q];
   assign bus.out_pc       = empty ? '0       : pc_mem[rd_ptr_q];
   assign bus.out_imm_type = empty ? IMM_NONE : imm_mem[rd_ptr_q];
   assign bus.out_illegal  = empty ? 1'b0     : ill_mem[rd_ptr_q];
endmodule
